// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select (stall > jump > branch > +4), IF/ID register.
// Build option: define BRANCH_DELAY_SLOT_EN to keep the instruction fetched alongside a taken redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic [31:0] instruction,
  output logic [31:0] instr_address,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit KEEP_SLOT = 1'b1;
`else
  localparam bit KEEP_SLOT = 1'b0;
`endif

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        redirect;
  logic        load_bubble;

  assign instr_address = pc;
  assign pc_plus4      = pc + 32'd4;
  assign redirect      = jump | branch_taken;
  assign target        = jump ? jump_target : branch_target;

  always_comb begin
    next_pc = pc_plus4;
    if (stall)         next_pc = pc;
    else if (redirect) next_pc = target & 32'hFFFF_FFFC;
  end

  // A flush beats a stall; a redirect squashes the wrong-path fetch unless it is a delay slot.
  always_comb begin
    load_bubble = 1'b0;
    if (flush)                      load_bubble = 1'b1;
    else if (!stall && redirect)    load_bubble = !KEEP_SLOT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= next_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instruction <= 32'h0000_0000;
      ifid_pc_plus4    <= 32'h0000_0000;
      ifid_valid       <= 1'b0;
    end else if (load_bubble) begin
      ifid_instruction <= 32'h0000_0000;
      ifid_pc_plus4    <= 32'h0000_0000;
      ifid_valid       <= 1'b0;
    end else if (!stall) begin
      ifid_instruction <= instruction;
      ifid_pc_plus4    <= pc_plus4;
      ifid_valid       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage; second instance covers PC wrap from 32'hFFFF_FFFC.
module tb_fetch_stage;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic        stall, flush, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] instruction, instr_address, ifid_instruction, ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] instruction2, instr_address2, ifid_instruction2, ifid_pc_plus42;
  logic        ifid_valid2;

  logic [31:0] imem [64];
  logic [64:0] exp_q [$];
  logic [31:0] model_pc;
  logic [64:0] model_ifid;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instruction  = imem[instr_address[7:2]];
  assign instruction2 = ~instr_address2;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instruction(instruction),
    .instr_address(instr_address), .ifid_instruction(ifid_instruction),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instruction(instruction2),
    .instr_address(instr_address2), .ifid_instruction(ifid_instruction2),
    .ifid_pc_plus4(ifid_pc_plus42), .ifid_valid(ifid_valid2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt);
    stall = s; flush = f; branch_taken = b; branch_target = bt; jump = j; jump_target = jt;
  endtask

  // One clock of dut: predict next PC and IF/ID, queue the prediction, compare after the edge.
  task automatic step(input string tag);
    logic [64:0] exp_v;
    logic [31:0] exp_pc;
    check({tag, "_pc_pre"}, instr_address, model_pc);
    if (stall)             exp_pc = model_pc;
    else if (jump)         exp_pc = {jump_target[31:2], 2'b00};
    else if (branch_taken) exp_pc = {branch_target[31:2], 2'b00};
    else                   exp_pc = model_pc + 32'd4;
    if (flush)                                  exp_v = '0;
    else if (stall)                             exp_v = model_ifid;
    else if ((jump || branch_taken) && !DS)     exp_v = '0;
    else                                        exp_v = {1'b1, imem[model_pc[7:2]], model_pc + 32'd4};
    exp_q.push_back(exp_v);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    check({tag, "_valid"}, {31'b0, ifid_valid}, {31'b0, exp_v[64]});
    check({tag, "_instr"}, ifid_instruction, exp_v[63:32]);
    check({tag, "_pcp4"}, ifid_pc_plus4, exp_v[31:0]);
    check({tag, "_pc"}, instr_address, exp_pc);
    model_pc   = exp_pc;
    model_ifid = exp_v;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'h3C00_0000 | (i << 2);
    imem[0] = 32'h200A_0001;
    rst_n = 1'b0; rst2_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_pc", instr_address, 32'h0);
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instruction, 32'h0);
    check("rst_pcp4", ifid_pc_plus4, 32'h0);
    model_pc = 32'h0; model_ifid = '0;
    rst_n = 1'b1;

    // First capture and sequential run: PC 0 -> 4 -> 8
    step("first");
    check("first_instr_lit", ifid_instruction, 32'h200A_0001);
    step("seq");

    // Stall at PC=8 for 3 cycles, branch ignored in the middle
    drive(1, 0, 0, 0, 0, 0);          step("stall1");
    drive(1, 0, 1, 32'h40, 0, 0);     step("stall2");
    drive(1, 0, 0, 0, 0, 0);          step("stall3");
    drive(0, 0, 0, 0, 0, 0);          step("unstall");
    check("unstall_pc12", instr_address, 32'hC);
    step("seq16");
    step("seq20");

    // Taken branch at PC=0x14 back to 0x8
    drive(0, 0, 1, 32'h8, 0, 0);      step("branch");
    check("branch_valid_cfg", {31'b0, ifid_valid}, {31'b0, DS});
    drive(0, 0, 0, 0, 0, 0);          step("post_branch");
    step("seq_c");

    // Jump beats branch, target low bits cleared
    drive(0, 0, 1, 32'h40, 1, 32'h23); step("jump_prio");
    check("jump_pc20", instr_address, 32'h20);
    drive(0, 0, 0, 0, 0, 0);          step("post_jump");

    // Flush with stall: bubble, PC holds; then flush alone
    drive(1, 1, 0, 0, 0, 0);          step("flush_stall");
    drive(0, 1, 0, 0, 0, 0);          step("flush");
    drive(0, 0, 0, 0, 0, 0);          step("post_flush");

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0, 32'($urandom_range(0, 255)),
            $urandom_range(0, 6) == 0, 32'($urandom_range(0, 255)));
      step("rand");
    end
    drive(0, 0, 0, 0, 0, 0);
    step("rand_end");

    // Async reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("async_pc", instr_address, 32'h0);
    check("async_valid", {31'b0, ifid_valid}, 32'h0);
    check("async_instr", ifid_instruction, 32'h0);

    // Wrap instance: reset value, one cycle wraps to 0, async reset restores it
    @(negedge clk);
    check("wrap_rst_pc", instr_address2, 32'hFFFF_FFFC);
    rst2_n = 1'b1;
    @(posedge clk); #1;
    check("wrap_pc", instr_address2, 32'h0);
    check("wrap_pcp4", ifid_pc_plus42, 32'h0);
    check("wrap_instr", ifid_instruction2, 32'h0000_0003);
    check("wrap_valid", {31'b0, ifid_valid2}, 32'h1);
    #2 rst2_n = 1'b0;
    #1;
    check("wrap_async_pc", instr_address2, 32'hFFFF_FFFC);
    check("wrap_async_valid", {31'b0, ifid_valid2}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned instruction into the IF/ID pipeline register. Handles stall, flush and branch/jump redirect from the decode stage. The PC advances by 4 each cycle unless a stall or redirect is active.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- Clk  input  1  core clock; all state updates on rising edge
- Rst  input  1  asynchronous, active-low reset
- Stall  input  1  hazard-unit stall; holds PC and IF/ID
- Flush  input  1  loads a bubble into IF/ID (exception/late squash)
- BranchTaken  input  1  taken conditional branch resolved in ID
- BranchTarget  input  32  branch target address
- Jump  input  1  j/jal/jr resolved in ID
- JumpTarget  input  32  jump target address
- Instruction  input  32  instruction-memory read data (combinational from InstrAddress)
- InstrAddress  output  32  current PC, byte address to instruction memory
- IFID_Instruction  output  32  registered instruction for decode
- IFID_PCPlus4  output  32  registered PC+4 of that instruction
- IFID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble

## Operation

- PC register drives InstrAddress directly; instruction memory returns Instruction in the same cycle.
- Next-PC selection, highest priority first:
  - Stall=1: PC holds; redirect inputs ignored (ID re-presents the redirect once the stall clears).
  - Jump=1: PC <= JumpTarget.
  - BranchTaken=1: PC <= BranchTarget.
  - otherwise: PC <= PC + 4.
- Target alignment: bits [1:0] of the selected target are forced to 0 before loading PC.
- PC+4 is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000, no flag.
- IF/ID update, highest priority first:
  - Flush=1: bubble (overrides Stall).
  - Stall=1: hold all IF/ID fields.
  - Redirect (Jump or BranchTaken) with delay slot disabled: bubble (wrong-path instruction squashed).
  - otherwise: IFID_Instruction <= Instruction, IFID_PCPlus4 <= PC+4, IFID_Valid <= 1.
- Bubble: IFID_Instruction = 32'h0000_0000 (sll $0,$0,0), IFID_PCPlus4 = 0, IFID_Valid = 0.
- Flush and Stall together: IF/ID becomes bubble, PC holds.

## Timing

- Reset (Rst=0, asynchronous, immediate): PC = RESET_PC, InstrAddress = RESET_PC, IFID_Instruction = 0, IFID_PCPlus4 = 0, IFID_Valid = 0.
- First rising edge after Rst release: IF/ID captures instruction at RESET_PC; PC = RESET_PC+4.
- Fetch latency: instruction at address A appears on IF/ID one edge after InstrAddress = A.
- Redirect asserted in cycle n (no stall): InstrAddress = target after edge n; target instruction in IF/ID after edge n+1. Cost: one slot (bubble, or delay-slot instruction).
- Rst assertion mid-operation overrides all inputs at once; in-flight IF/ID contents discarded.
- No combinational path from any input to InstrAddress; IF/ID outputs are registered.

## Configuration

- BRANCH_DELAY_SLOT_EN defined: the instruction fetched in the same cycle as a taken redirect (architectural delay slot, at branch PC+4) is kept in IF/ID with IFID_Valid=1. MIPS-I delay-slot semantics.
- Not defined: that instruction is replaced by a bubble. Next-PC priority and all other behaviour are unchanged.

## Test plan

- Reset/start: hold Rst=0, memory[0]=32'h200A0001. Required during reset: InstrAddress=0, IFID_Valid=0. Release Rst. Required after first edge: IFID_Instruction=32'h200A0001, IFID_PCPlus4=4, InstrAddress=4.
- Sequential: 5 free-running cycles. Required: InstrAddress 0,4,8,12,16 and IFID_PCPlus4 trailing by one cycle, every capture Valid=1.
- Stall: assert Stall for 3 cycles at PC=8, with BranchTaken=1 and target 0x40 in the 2nd cycle. Required: InstrAddress stays 8, IF/ID unchanged, branch ignored. Release Stall. Required: PC=12 next.
- Branch: BranchTaken=1, BranchTarget=0x8 while PC=0x14. Required: InstrAddress=0x8 next. Macro off: IF/ID bubble. Macro on: IF/ID holds instruction at 0x14 with Valid=1 and PCPlus4=0x18.
- Priority/alignment: Jump=1 with JumpTarget=0x23, plus BranchTaken=1 with target 0x40. Required: PC=0x20. Flush=1 with Stall=1: IF/ID becomes bubble, PC holds.
- Async reset and wrap: RESET_PC=32'hFFFF_FFFC, run 1 cycle. Required: PC=0. Drop Rst between edges. Required: PC=32'hFFFF_FFFC and Valid=0 immediately, without waiting for a clock edge.
